// File: rtl/dcache_if.sv
// Pipeline-side and memory-side signals of the L1 data cache.
// slave = cache, master = pipeline/memory environment.
interface dcache_if #(
  parameter int LINE_BITS = 256
);
  logic                 p1_req_i;
  logic                 p1_write_i;
  logic [31:0]          p1_addr_i;
  logic [31:0]          p1_data_i;
  logic [31:0]          p1_data_o;
  logic                 p1_stall_o;
  logic                 mem_enable_o;
  logic                 mem_write_o;
  logic [31:0]          mem_addr_o;
  logic [LINE_BITS-1:0] mem_data_o;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;

  modport slave (
    input  p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    output p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );

  modport master (
    output p1_req_i, p1_write_i, p1_addr_i, p1_data_i, mem_data_i, mem_ack_i,
    input  p1_data_o, p1_stall_o, mem_enable_o, mem_write_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache.
// Stalls the pipeline while a miss is written back and/or refilled.
module dcache_controller #(
  parameter int NUM_LINES = 32,
  parameter int LINE_BITS = 256
) (
  input logic     clk_i,
  input logic     rst_i,
  dcache_if.slave bus
);
  localparam int IDX_W  = $clog2(NUM_LINES);
  localparam int OFF_W  = $clog2(LINE_BITS / 8);
  localparam int WORD_W = OFF_W - 2;
  localparam int TAG_W  = 32 - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_e;

  state_e                               state_q, state_d;
  logic [NUM_LINES-1:0]                 valid_q, dirty_q;
  logic [NUM_LINES-1:0][TAG_W-1:0]      tag_q;
  logic [NUM_LINES-1:0][LINE_BITS-1:0]  line_q;
  logic [TAG_W-1:0]                     miss_tag_q;
  logic [IDX_W-1:0]                     miss_idx_q;
  logic                                 en_q, en_d, wr_q, wr_d;
  logic [31:0]                          addr_q, addr_d;
  logic [LINE_BITS-1:0]                 data_q, data_d;

  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WORD_W-1:0] req_word;
  logic              hit, miss, fill, unused_bits;

  assign req_tag     = bus.p1_addr_i[31 -: TAG_W];
  assign req_idx     = bus.p1_addr_i[OFF_W +: IDX_W];
  assign req_word    = bus.p1_addr_i[2 +: WORD_W];
  assign unused_bits = ^bus.p1_addr_i[1:0];

  assign hit  = bus.p1_req_i && (state_q == IDLE) && valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign miss = bus.p1_req_i && (state_q == IDLE) && !hit;
  assign fill = (state_q == ALLOCATE) && bus.mem_ack_i;

  assign bus.p1_stall_o   = bus.p1_req_i && !hit;
  assign bus.p1_data_o    = hit ? line_q[req_idx][{req_word, 5'b0} +: 32] : 32'h0;
  assign bus.mem_enable_o = en_q;
  assign bus.mem_write_o  = wr_q;
  assign bus.mem_addr_o   = addr_q;
  assign bus.mem_data_o   = data_q;

  // Memory-side outputs are computed here and registered, so they appear one cycle after the decision.
  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (miss) begin
          en_d = 1'b1;
          if (valid_q[req_idx] && dirty_q[req_idx]) begin
            state_d = WRITEBACK;
            wr_d    = 1'b1;
            addr_d  = {tag_q[req_idx], req_idx, {OFF_W{1'b0}}};
            data_d  = line_q[req_idx];
          end else begin
            state_d = ALLOCATE;
            wr_d    = 1'b0;
            addr_d  = {req_tag, req_idx, {OFF_W{1'b0}}};
          end
        end
      end
      WRITEBACK: begin
        if (bus.mem_ack_i) begin
          state_d = ALLOCATE;
          wr_d    = 1'b0;
          addr_d  = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};
        end
      end
      ALLOCATE: begin
        if (bus.mem_ack_i) begin
          state_d = IDLE;
          en_d    = 1'b0;
          wr_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      dirty_q    <= '0;
      en_q       <= 1'b0;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
      miss_tag_q <= '0;
      miss_idx_q <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      // The miss target is captured so a dropped request still completes its refill.
      if (miss) begin
        miss_tag_q <= req_tag;
        miss_idx_q <= req_idx;
      end
      if (fill) begin
        valid_q[miss_idx_q] <= 1'b1;
        dirty_q[miss_idx_q] <= 1'b0;
      end else if (hit && bus.p1_write_i) begin
        dirty_q[req_idx] <= 1'b1;
      end
    end
  end

  // Tags and data carry no reset; valid bits gate every use of them.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      line_q[miss_idx_q] <= bus.mem_data_i;
      tag_q[miss_idx_q]  <= miss_tag_q;
    end else if (hit && bus.p1_write_i) begin
      line_q[req_idx][{req_word, 5'b0} +: 32] <= bus.p1_data_i;
    end
  end
endmodule
